// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: packs a byte stream of operand matrices A then B
// into row-major buses for the sequential matrix-multiply stage.
module matrix_stream_loader #(
  parameter int A_ROWS = 2,
  parameter int A_COLS = 2,
  parameter int B_ROWS = 2,
  parameter int B_COLS = 2,
  parameter int A_LEN  = 8*A_ROWS*A_COLS,
  parameter int B_LEN  = 8*B_ROWS*B_COLS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [A_LEN-1:0] a_out,
  output logic [B_LEN-1:0] b_out,
  output logic             mat_valid,
  output logic             load_done,
  output logic             busy,
  output logic             dim_err
);

  localparam int A_N = A_ROWS*A_COLS;
  localparam int B_N = B_ROWS*B_COLS;
  localparam logic DIM_ERR = (A_COLS != B_ROWS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [A_LEN-1:0] a_q, a_d;
  logic [B_LEN-1:0] b_q, b_d;
  logic             mv_q, mv_d;
  logic             xfer;

  assign in_ready  = (state_q == S_LOAD_A) ||
                     (state_q == S_LOAD_B);
  assign busy      = in_ready;
  assign load_done = (state_q == S_DONE);
  assign dim_err   = DIM_ERR;
  assign mat_valid = mv_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign xfer      = in_valid && in_ready;

  // State, counter and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mv_q    <= mv_d;
    end
  end

  // Next state: the counter counts down, so the first byte
  // lands in the top byte, i.e. element (0,0)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mv_d    = mv_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !DIM_ERR) begin
          state_d = S_LOAD_A;
          a_d     = '0;
          b_d     = '0;
          mv_d    = 1'b0;
          cnt_d   = 32'(A_N-1);
        end
      end
      S_LOAD_A: begin
        if (xfer) begin
          for (int i = 0; i < A_N; i++) begin
            if (cnt_q == 32'(i)) a_d[8*i +: 8] = in_data;
          end
          if (cnt_q == '0) begin
            state_d = S_LOAD_B;
            cnt_d   = 32'(B_N-1);
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
      end
      S_LOAD_B: begin
        if (xfer) begin
          for (int i = 0; i < B_N; i++) begin
            if (cnt_q == 32'(i)) b_d[8*i +: 8] = in_data;
          end
          if (cnt_q == '0) begin
            state_d = S_DONE;
            mv_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
